// File: rtl/dcache_pkg.sv
// Shared types and geometry for the data-cache controller.
// Holds the controller state enum, line/word/offset widths and the helpers
// that derive the index and tag field widths from the number of lines.
package dcache_pkg;

  localparam int ADDR_W   = 32;
  localparam int LINE_W   = 256;
  localparam int WORD_W   = 32;
  localparam int OFFSET_W = 5;
  localparam int WORDS    = LINE_W / WORD_W;
  localparam int SEL_W    = $clog2(WORDS);

  typedef enum logic [2:0] {
    IDLE,
    MISS,
    WRITEBACK,
    READMISS,
    READMISSOK
  } state_t;

  function automatic int index_width(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_width(input int lines);
    return ADDR_W - OFFSET_W - $clog2(lines);
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag and data storage for the direct-mapped cache: one entry per line.
// Single port (one index for read and write), synchronous write,
// asynchronous read.
// Ports:
//   clk_i   clock
//   we_i    write enable for entry idx_i
//   idx_i   line index (read and write)
//   tag_i   tag to write
//   data_i  line to write
//   tag_o   stored tag at idx_i
//   data_o  stored line at idx_i
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int LINES = 32,
  parameter int TAG_W = tag_width(LINES)
) (
  input  logic                      clk_i,
  input  logic                      we_i,
  input  logic [$clog2(LINES)-1:0]  idx_i,
  input  logic [TAG_W-1:0]          tag_i,
  input  logic [LINE_W-1:0]         data_i,
  output logic [TAG_W-1:0]          tag_o,
  output logic [LINE_W-1:0]         data_o
);

  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINE_W-1:0] data_mem [LINES];

  // NOTE: storage arrays carry no reset; the controller's valid bits decide
  // whether an entry means anything, so resetting them would only cost area.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_mem[idx_i]  <= tag_i;
      data_mem[idx_i] <= data_i;
    end
  end

  assign tag_o  = tag_mem[idx_i];
  assign data_o = data_mem[idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data-cache controller sitting
// between the MEM stage and off-chip data memory. Hits complete in the
// request cycle; misses stall the pipeline while the dirty victim is written
// back and the line is filled.
// Optional feature: define DCACHE_STAT_EN to add saturating hit/miss counters.
// Ports:
//   clk_i, rst_i (async, active-low)
//   p1_req_i/p1_write_i/p1_addr_i/p1_data_i  MEM-stage access
//   p1_data_o   load data;  p1_stall_o  pipeline halt
//   mem_enable_o/mem_write_o/mem_addr_o/mem_data_o  memory request
//   mem_data_i  fill line;  mem_ack_i  one-cycle completion pulse
//   hit_cnt_o/miss_cnt_o  (DCACHE_STAT_EN only)
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p1_req_i,
  input  logic              p1_write_i,
  input  logic [31:0]       p1_addr_i,
  input  logic [31:0]       p1_data_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
`ifdef DCACHE_STAT_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int IDX_W = index_width(LINES);
  localparam int TAG_W = tag_width(LINES);

  state_t state_q, state_d;

  logic [LINES-1:0]  valid_q, dirty_q;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  req_tag, line_tag;
  logic [SEL_W-1:0]  word_sel;
  logic [LINE_W-1:0] line_rd, line_merged, wr_line;
  logic              hit, store_hit, fill, sram_we;
  logic              addr_unused;

  assign idx         = p1_addr_i[OFFSET_W +: IDX_W];
  assign req_tag     = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign word_sel    = p1_addr_i[2 +: SEL_W];
  assign addr_unused = ^p1_addr_i[1:0];

  assign hit       = valid_q[idx] & (line_tag == req_tag);
  assign store_hit = (state_q == IDLE) & p1_req_i & p1_write_i & hit;
  assign fill      = (state_q == READMISS) & mem_ack_i;
  assign sram_we   = store_hit | fill;
  assign wr_line   = fill ? mem_data_i : line_merged;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    line_merged = line_rd;
    line_merged[word_sel*WORD_W +: WORD_W] = p1_data_i;
  end

  // Both write sources use the request tag: a store hit rewrites the same
  // tag, a fill installs the tag of the missing address.
  dcache_sram #(.LINES(LINES), .TAG_W(TAG_W)) u_sram (
    .clk_i  (clk_i),
    .we_i   (sram_we),
    .idx_i  (idx),
    .tag_i  (req_tag),
    .data_i (wr_line),
    .tag_o  (line_tag),
    .data_o (line_rd)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (store_hit) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (p1_req_i && !hit) state_d = MISS;
      MISS:       state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : READMISS;
      WRITEBACK:  if (mem_ack_i) state_d = READMISS;
      READMISS:   if (mem_ack_i) state_d = READMISSOK;
      READMISSOK: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Memory-side signals decode from state alone, so enable falls the cycle
  // after ack and drops with the asynchronous reset of state_q.
  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    p1_stall_o   = p1_req_i & ~((state_q == IDLE) & hit);
    p1_data_o    = '0;
    if (p1_req_i && !p1_stall_o) p1_data_o = line_rd[word_sel*WORD_W +: WORD_W];
    unique case (state_q)
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {line_tag, idx, {OFFSET_W{1'b0}}};
        mem_data_o   = line_rd;
      end
      READMISS: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {req_tag, idx, {OFFSET_W{1'b0}}};
      end
      default: ;
    endcase
  end

`ifdef DCACHE_STAT_EN
  // The first IDLE cycle after a fill re-presents an access already counted
  // as a miss; prev_state_q lets the hit counter skip it.
  state_t prev_state_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      prev_state_q <= IDLE;
      hit_cnt_o    <= '0;
      miss_cnt_o   <= '0;
    end else begin
      prev_state_q <= state_q;
      if (state_q == IDLE && p1_req_i && !hit && miss_cnt_o != '1)
        miss_cnt_o <= miss_cnt_o + 32'd1;
      if (state_q == IDLE && p1_req_i && hit && prev_state_q != READMISSOK
          && hit_cnt_o != '1)
        hit_cnt_o <= hit_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed testbench for dcache_ctrl: cold fill, store hit, dirty eviction,
// delayed ack, ignored ack and reset during write-back. Counter checks are
// included when DCACHE_STAT_EN is defined.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              p1_req_i = 1'b0;
  logic              p1_write_i = 1'b0;
  logic [31:0]       p1_addr_i = '0;
  logic [31:0]       p1_data_i = '0;
  logic [31:0]       p1_data_o;
  logic              p1_stall_o;
  logic              mem_enable_o;
  logic              mem_write_o;
  logic [31:0]       mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic [LINE_W-1:0] mem_data_i = '0;
  logic              mem_ack_i = 1'b0;
`ifdef DCACHE_STAT_EN
  logic [31:0]       hit_cnt_o;
  logic [31:0]       miss_cnt_o;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  dcache_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .p1_req_i     (p1_req_i),
    .p1_write_i   (p1_write_i),
    .p1_addr_i    (p1_addr_i),
    .p1_data_i    (p1_data_i),
    .p1_data_o    (p1_data_o),
    .p1_stall_o   (p1_stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
`ifdef DCACHE_STAT_EN
    ,
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge; inputs change and outputs
  // are sampled here, well clear of the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [LINE_W-1:0] make_line(input logic [31:0] base,
                                                  input logic [31:0] w0);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < WORDS; i++) l[i*WORD_W +: WORD_W] = base + 32'(i);
    l[31:0] = w0;
    return l;
  endfunction

  task automatic test_reset();
    rst_i = 1'b0;
    repeat (2) step();
    total_cnt++;
    if (mem_enable_o !== 1'b0 || mem_write_o !== 1'b0) $display("FAIL reset_mem_ctl: en=%b wr=%b required 0/0", mem_enable_o, mem_write_o);
    else pass_cnt++;
    total_cnt++;
    if (mem_addr_o !== 32'h0 || mem_data_o !== '0) $display("FAIL reset_mem_bus: addr=%h required 0", mem_addr_o);
    else pass_cnt++;
    rst_i = 1'b1;
    step();
    total_cnt++;
    if (p1_stall_o !== 1'b0 || p1_data_o !== 32'h0) $display("FAIL reset_p1: stall=%b data=%h required 0/0", p1_stall_o, p1_data_o);
    else pass_cnt++;
    total_cnt++;
    if (dut.state_q !== IDLE || dut.valid_q !== '0 || dut.dirty_q !== '0) $display("FAIL reset_state: state=%0d valid=%h dirty=%h required IDLE/0/0", dut.state_q, dut.valid_q, dut.dirty_q);
    else pass_cnt++;
  endtask

  task automatic test_cold_load();
    p1_req_i = 1'b1; p1_write_i = 1'b0; p1_addr_i = 32'h0000_0040;
    #1;
    total_cnt++;
    if (p1_stall_o !== 1'b1) $display("FAIL cold_stall_now: got %b required 1", p1_stall_o);
    else pass_cnt++;
    step(); // MISS
    total_cnt++;
    if (p1_stall_o !== 1'b1 || mem_enable_o !== 1'b0) $display("FAIL cold_miss: stall=%b en=%b required 1/0", p1_stall_o, mem_enable_o);
    else pass_cnt++;
    step(); // READMISS
    total_cnt++;
    if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b0 || mem_addr_o !== 32'h40) $display("FAIL cold_readmiss: en=%b wr=%b addr=%h required 1/0/00000040", mem_enable_o, mem_write_o, mem_addr_o);
    else pass_cnt++;
    mem_data_i = make_line(32'hA000_0000, 32'hDEAD_BEEF);
    mem_ack_i  = 1'b1;
    step(); // READMISSOK
    mem_ack_i = 1'b0;
    total_cnt++;
    if (p1_stall_o !== 1'b1 || mem_enable_o !== 1'b0) $display("FAIL cold_readmissok: stall=%b en=%b required 1/0", p1_stall_o, mem_enable_o);
    else pass_cnt++;
    step(); // IDLE, now a hit
    total_cnt++;
    if (p1_stall_o !== 1'b0 || p1_data_o !== 32'hDEAD_BEEF) $display("FAIL cold_data: stall=%b data=%h required 0/deadbeef", p1_stall_o, p1_data_o);
    else pass_cnt++;
  endtask

  task automatic test_store_hit();
    step();
    p1_req_i = 1'b1; p1_write_i = 1'b1; p1_addr_i = 32'h44; p1_data_i = 32'h1234_5678;
    #1;
    total_cnt++;
    if (p1_stall_o !== 1'b0) $display("FAIL store_nostall: got %b required 0", p1_stall_o);
    else pass_cnt++;
    step();
    p1_write_i = 1'b0;
    #1;
    total_cnt++;
    if (p1_stall_o !== 1'b0 || p1_data_o !== 32'h1234_5678) $display("FAIL store_readback: stall=%b data=%h required 0/12345678", p1_stall_o, p1_data_o);
    else pass_cnt++;
    total_cnt++;
    if (dut.dirty_q[2] !== 1'b1) $display("FAIL store_dirty: got %b required 1", dut.dirty_q[2]);
    else pass_cnt++;
    step();
    p1_req_i = 1'b0;
    #1;
    total_cnt++;
    if (p1_stall_o !== 1'b0 || p1_data_o !== 32'h0) $display("FAIL idle_noreq: stall=%b data=%h required 0/0", p1_stall_o, p1_data_o);
    else pass_cnt++;
  endtask

  task automatic test_dirty_miss();
    step();
    p1_req_i = 1'b1; p1_write_i = 1'b0; p1_addr_i = 32'h440;
    #1;
    total_cnt++;
    if (p1_stall_o !== 1'b1) $display("FAIL evict_stall: got %b required 1", p1_stall_o);
    else pass_cnt++;
    step(); // MISS
    step(); // WRITEBACK
    total_cnt++;
    if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b1 || mem_addr_o !== 32'h40) $display("FAIL wb_ctl: en=%b wr=%b addr=%h required 1/1/00000040", mem_enable_o, mem_write_o, mem_addr_o);
    else pass_cnt++;
    total_cnt++;
    if (mem_data_o[63:32] !== 32'h1234_5678 || mem_data_o[31:0] !== 32'hDEAD_BEEF) $display("FAIL wb_data: w1=%h w0=%h required 12345678/deadbeef", mem_data_o[63:32], mem_data_o[31:0]);
    else pass_cnt++;
    mem_ack_i = 1'b1;
    step(); // READMISS
    mem_ack_i = 1'b0;
    total_cnt++;
    if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b0 || mem_addr_o !== 32'h440) $display("FAIL evict_fill_req: en=%b wr=%b addr=%h required 1/0/00000440", mem_enable_o, mem_write_o, mem_addr_o);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      step();
      total_cnt++;
      if (mem_enable_o !== 1'b1 || p1_stall_o !== 1'b1 || dut.state_q !== READMISS) $display("FAIL ack_wait[%0d]: en=%b stall=%b state=%0d required 1/1/READMISS", i, mem_enable_o, p1_stall_o, dut.state_q);
      else pass_cnt++;
    end
    mem_data_i = make_line(32'hB000_0000, 32'hB000_0000);
    mem_ack_i  = 1'b1;
    step(); // READMISSOK
    mem_ack_i = 1'b0;
    step(); // IDLE
    total_cnt++;
    if (p1_stall_o !== 1'b0 || p1_data_o !== 32'hB000_0000) $display("FAIL evict_data: stall=%b data=%h required 0/b0000000", p1_stall_o, p1_data_o);
    else pass_cnt++;
    total_cnt++;
    if (dut.dirty_q[2] !== 1'b0) $display("FAIL evict_clean: dirty=%b required 0", dut.dirty_q[2]);
    else pass_cnt++;
    step();
    p1_req_i = 1'b0;
`ifdef DCACHE_STAT_EN
    step();
    total_cnt++;
    if (hit_cnt_o !== 32'd2 || miss_cnt_o !== 32'd2) $display("FAIL stat_counts: hit=%0d miss=%0d required 2/2", hit_cnt_o, miss_cnt_o);
    else pass_cnt++;
`endif
  endtask

  task automatic test_ack_ignored();
    step();
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    #1;
    total_cnt++;
    if (dut.state_q !== IDLE || mem_enable_o !== 1'b0) $display("FAIL ack_idle: state=%0d en=%b required IDLE/0", dut.state_q, mem_enable_o);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_miss();
    step();
    p1_req_i = 1'b1; p1_write_i = 1'b1; p1_addr_i = 32'h440; p1_data_i = 32'hCAFE_F00D;
    #1;
    total_cnt++;
    if (p1_stall_o !== 1'b0) $display("FAIL dirty_store: stall=%b required 0", p1_stall_o);
    else pass_cnt++;
    step();
    p1_write_i = 1'b0; p1_addr_i = 32'h40;
    step(); // MISS
    step(); // WRITEBACK
    total_cnt++;
    if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b1 || mem_addr_o !== 32'h440 || mem_data_o[31:0] !== 32'hCAFE_F00D) $display("FAIL wb2: en=%b wr=%b addr=%h w0=%h required 1/1/00000440/cafef00d", mem_enable_o, mem_write_o, mem_addr_o, mem_data_o[31:0]);
    else pass_cnt++;
    #1;
    rst_i = 1'b0;
    #1;
    total_cnt++;
    if (dut.state_q !== IDLE || mem_enable_o !== 1'b0) $display("FAIL rst_mid: state=%0d en=%b required IDLE/0", dut.state_q, mem_enable_o);
    else pass_cnt++;
    total_cnt++;
    if (dut.valid_q !== '0 || p1_stall_o !== 1'b1) $display("FAIL rst_invalid: valid=%h stall=%b required 0/1", dut.valid_q, p1_stall_o);
    else pass_cnt++;
    #1;
    rst_i = 1'b1;
    step();
    p1_addr_i = 32'h44;
    #1;
    total_cnt++;
    if (p1_stall_o !== 1'b1) $display("FAIL post_rst_miss: stall=%b required 1", p1_stall_o);
    else pass_cnt++;
    p1_req_i = 1'b0;
    #1;
    total_cnt++;
    if (p1_stall_o !== 1'b0) $display("FAIL post_rst_noreq: stall=%b required 0", p1_stall_o);
    else pass_cnt++;
    step();
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_store_hit();
    test_dirty_miss();
    test_ack_ignored();
    test_reset_mid_miss();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data-cache controller between the MEM stage and the off-chip data memory. Answers MEM-stage loads and stores in the same cycle on a hit. On a miss it raises `p1_stall_o`, which drives the pipeline halt inputs (including MEM/WB) until the line is filled, and runs the dirty write-back and line-fill handshake on the memory side.

## Interface
- `LINES`, 32: cache lines; index width is log2(LINES).
- `LINE_W`, 256: line width in bits (32 bytes, eight 32-bit words).
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous, active-low reset.
- `p1_req_i`  in  1  MEM-stage access request.
- `p1_write_i`  in  1  1 = store, 0 = load.
- `p1_addr_i`  in  32  byte address.
- `p1_data_i`  in  32  store data.
- `p1_data_o`  out  32  load data, valid when `p1_req_i & ~p1_stall_o`.
- `p1_stall_o`  out  1  halt request to pipeline.
- `mem_enable_o`  out  1  memory request.
- `mem_write_o`  out  1  1 = write-back, 0 = fill.
- `mem_addr_o`  out  32  line-aligned address, bits [4:0] = 0.
- `mem_data_o`  out  LINE_W  write-back line.
- `mem_data_i`  in  LINE_W  fill line.
- `mem_ack_i`  in  1  one-cycle completion pulse.

## Operation
- Address split, with LINES=32:
  - offset [4:0]; word select [4:2].
  - index [9:5].
  - tag [31:10], 22 bits.
- Per-line state:
  - valid and dirty bits in resettable flops.
  - tag and data in SRAM, no reset.
- Hit = `valid[index] & (tag == stored tag)`.
- `p1_stall_o` = `p1_req_i & ~(state==IDLE & hit)`. It is combinational.
- Load hit: `p1_data_o` = the selected word, combinationally.
- Store hit: the word is merged into the line and dirty is set at the next posedge.
- FSM states: IDLE, MISS, WRITEBACK, READMISS, READMISSOK.
  - IDLE → MISS on `p1_req_i & ~hit`.
  - MISS → WRITEBACK if the victim is valid and dirty; otherwise → READMISS.
  - WRITEBACK: `mem_enable_o=1`, `mem_write_o=1`, `mem_addr_o={old tag, index, 5'b0}`, `mem_data_o` = victim line. On `mem_ack_i` → READMISS.
  - READMISS: `mem_enable_o=1`, `mem_write_o=0`, `mem_addr_o={req tag, index, 5'b0}`. On `mem_ack_i`, write `mem_data_i`, the tag, valid=1 and dirty=0, then → READMISSOK.
  - READMISSOK → IDLE unconditionally. In IDLE the access now hits, stall drops, and a store merges and sets dirty.
- `mem_enable_o` and `mem_write_o` decode from state only. Enable therefore drops the cycle after ack.
- `mem_ack_i` outside WRITEBACK/READMISS is ignored.
- The request inputs must be held stable by the pipeline while stalled.

## Timing
- Reset values: state=IDLE, all valid and dirty bits 0, `mem_enable_o=0`, `mem_write_o=0`, `mem_addr_o=0`, `mem_data_o=0`, `p1_data_o=0` (forced in IDLE with no request).
- `p1_stall_o` is 0 when `p1_req_i=0`.
- Hit latency: 0 cycles, with no stall.
- Clean miss stall cycles: 3 + fill wait, where the fill wait counts the cycles from READMISS entry up to and including ack.
- Dirty miss stall cycles: 3 + write-back wait + fill wait. The write-back wait counts the cycles from WRITEBACK entry up to and including ack.
- Ack arriving in the first cycle of WRITEBACK or READMISS is legal.
- Reset mid-miss:
  - Immediate return to IDLE; `mem_enable_o` drops asynchronously.
  - All lines become invalid.
  - The in-flight memory transaction is abandoned. Memory tolerates this.
- A request that drops while in IDLE has no effect. Requests are not sampled outside IDLE.

## Configuration
- `DCACHE_STAT_EN` defined: adds outputs `hit_cnt_o` and `miss_cnt_o` (32-bit each, saturating, reset to 0).
  - `miss_cnt_o` increments on IDLE→MISS.
  - `hit_cnt_o` increments on an IDLE cycle with `p1_req_i & hit` whose previous state was not READMISSOK. This counts each access exactly once.
- Not defined: the ports and counters are absent and behaviour is otherwise identical.

## Structure
- Package `dcache_pkg` holds:
  - the state enum;
  - LINE_W, WORD_W=32 and OFFSET_W=5;
  - the tag/index field-width functions.
- Sub-module `dcache_sram`:
  - single-port tag and data arrays, one entry per line;
  - synchronous write, asynchronous read.
- Controller: valid/dirty flops, FSM, word merge and mux.

## Test plan
- Cold load of 0x0000_0040:
  - stall is 1 at once;
  - READMISS with `mem_addr_o=0x40`;
  - ack with a line whose word0 is 0xDEADBEEF;
  - two cycles later stall is 0 and `p1_data_o=0xDEADBEEF`.
- Store 0x12345678 to 0x44 after that fill, then load 0x44:
  - the store completes with no stall;
  - the load returns 0x12345678 and dirty[2] is 1.
- Load 0x0000_0440 (same index 2, different tag) after that store:
  - the WRITEBACK phase drives `mem_addr_o=0x40` with word1 of `mem_data_o`=0x12345678;
  - after ack, READMISS drives `mem_addr_o=0x440`.
- Ack held off 10 cycles in READMISS: `mem_enable_o` stays 1 throughout, stall stays 1, and there is no state change.
- Reset pulse asserted while in WRITEBACK: state=IDLE, `mem_enable_o=0`, and the next access to any address misses.
- With `DCACHE_STAT_EN` defined, run the three accesses above: `hit_cnt_o=2` and `miss_cnt_o=2`.
